sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
Command arbiter between the SDRAM sub-controllers (init, auto-refresh, write, read) and the SDRAM pins.
- Grants exactly one requester at a time with fixed priority: refresh > write > read.
- Muxes the granted requester's {cmd, ba, addr} onto the chip pins and controls the DQ tristate.
- Sits directly downstream of the auto-refresh block: consumes aref_req/aref_cmd/aref_ba/aref_addr/aref_end and returns aref_en.

Parameters:
DATA_W, 16, SDRAM DQ width
ADDR_W, 11, SDRAM address bus width (ba fixed at 2 bits)

Ports:
sys_clk  in  1  system clock; all logic on posedge
sys_rst_n  in  1  asynchronous active-low reset
init_end  in  1  power-up init complete (level, stays high)
init_cmd/init_ba/init_addr  in  4/2/ADDR_W  init block command bus
aref_req  in  1  refresh request (level, dropped by requester on ack)
aref_end  in  1  one-cycle refresh-done pulse
aref_cmd/aref_ba/aref_addr  in  4/2/ADDR_W  refresh command bus
wr_req, wr_end  in  1 each  write request level / one-cycle done pulse
wr_cmd/wr_ba/wr_addr  in  4/2/ADDR_W  write command bus
wr_sdram_en  in  1  write block drives DQ this cycle
wr_sdram_data  in  DATA_W  write data
rd_req, rd_end  in  1 each  read request level / one-cycle done pulse
rd_cmd/rd_ba/rd_addr  in  4/2/ADDR_W  read command bus
aref_en, wr_en, rd_en  out  1 each  grant to refresh/write/read block
sdram_cke  out  1  clock enable, constant 1
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  {cs_n,ras_n,cas_n,we_n} = selected cmd[3:0]
sdram_ba  out  2  bank address
sdram_addr  out  ADDR_W  row/column address
sdram_dq  inout  DATA_W  data bus
rd_sdram_data  out  DATA_W  sdram_dq passed straight to the read block

Behaviour:
States: INIT, ARBIT, AREF, WRITE, READ. State register is async reset to INIT.
Transitions:
- INIT -> ARBIT when init_end=1.
- ARBIT -> AREF if aref_req; else WRITE if wr_req; else READ if rd_req; else stay. Same-cycle requests resolve by this priority.
- AREF -> ARBIT on aref_end. WRITE -> ARBIT on wr_end. READ -> ARBIT on rd_end.
- Illegal encoding -> INIT.
Grants:
- Combinational from state: aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ).
- Grant rises one cycle after the ARBIT decision and falls the cycle after the *_end pulse.
- Minimum one ARBIT cycle between consecutive grants. Back-to-back refreshes are impossible because the requester drops aref_req on its precharge ack.
No preemption:
- A request arriving while another grant is active waits in its level until return to ARBIT.
- Burst lengths upstream are bounded so the refresh interval (1875 cycles) is never violated.
Command mux (combinational, zero latency):
- INIT -> init_*; AREF -> aref_*; WRITE -> wr_*; READ -> rd_*.
- ARBIT / default -> cmd 4'b0111 (NOP), ba 2'b11, addr all-ones.
DQ:
- sdram_dq = wr_sdram_data when wr_sdram_en=1, else high-Z.
- rd_sdram_data = sdram_dq always.
- wr_sdram_en is honoured only in WRITE; it is forced to high-Z otherwise.
Reset:
- Values: state=INIT; aref_en/wr_en/rd_en=0; pins follow init_* (NOP while init is in reset); dq high-Z; cke=1.
- Reset asserted mid-operation drops every grant immediately, asynchronously.
- init_end falling while not in INIT is ignored.

Decomposition:
Shared package sdram_pkg:
- Command encodings NOP=4'b0111, P_CHARGE=4'b0010, A_REF=4'b0001, ACTIVE=4'b0011, WRITE=4'b0100, READ=4'b0101, M_REG=4'b0000, B_STOP=4'b0110.
- Arbiter state encoding.
- Idle bus values (ba 2'b11, addr all-ones).
No sub-module: the state machine and mux are a single file.

Test Plan:
- Reset, then init_end=0 with init_cmd=4'b0000 -> pins show 0000, all grants 0. Raise init_end -> state ARBIT next cycle, pins NOP 0111/ba 11/addr 7FF.
- aref_req, wr_req and rd_req all high in the same ARBIT cycle -> only aref_en=1 next cycle. After aref_end, one ARBIT cycle, then wr_en=1. After wr_end, one ARBIT cycle, then rd_en=1.
- In AREF, aref_cmd=0010 then 0001 -> sdram_cs_n/ras_n/cas_n/we_n equal 0,0,1,0 then 0,0,0,1 in the same cycles.
- aref_req rises mid-WRITE -> wr_en held until wr_end, aref_en asserted exactly 2 cycles after the wr_end cycle.
- WRITE with wr_sdram_en=1, data 16'hA5A5 -> sdram_dq=A5A5. wr_sdram_en=1 in READ -> sdram_dq high-Z, rd_sdram_data tracks bench-driven 16'h3C3C.
- sys_rst_n pulsed low during WRITE -> wr_en=0 and pins=init_* with no clock edge. After release, the arbiter waits in INIT for init_end.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, arbiter state encoding
// and the values driven on the bank/address pins while the bus is idle.
package sdram_pkg;

   // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP      = 4'b0111;
   localparam logic [3:0] CMD_P_CHARGE = 4'b0010;
   localparam logic [3:0] CMD_A_REF    = 4'b0001;
   localparam logic [3:0] CMD_ACTIVE   = 4'b0011;
   localparam logic [3:0] CMD_WRITE    = 4'b0100;
   localparam logic [3:0] CMD_READ     = 4'b0101;
   localparam logic [3:0] CMD_M_REG    = 4'b0000;
   localparam logic [3:0] CMD_B_STOP   = 4'b0110;

   // Bank address parked on the pins while nobody owns the bus
   localparam logic [1:0] IDLE_BA = 2'b11;

   // Arbiter states
   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } arb_state_e;

   // Idle address: all ones at whatever address width is in use
   function automatic logic [31:0] idle_addr_word();
      return 32'hFFFF_FFFF;
   endfunction

endpackage

// File: rtl/sdram_arbit_if.sv
// SDRAM command/address pin bundle. The arbiter drives it through the
// master modport; the memory (or a bench) observes it through slave.
interface sdram_arbit_if #(
   parameter int ADDR_W = 11
);
   logic              sdram_cke;
   logic              sdram_cs_n;
   logic              sdram_ras_n;
   logic              sdram_cas_n;
   logic              sdram_we_n;
   logic [1:0]        sdram_ba;
   logic [ADDR_W-1:0] sdram_addr;

   modport master (
      output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
      output sdram_ba, sdram_addr
   );

   modport slave (
      input sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
      input sdram_ba, sdram_addr
   );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: after power-up init, grants the pins to one of
// refresh / write / read at a time (fixed priority, no preemption),
// muxes the owner's command bus onto the pins and gates the DQ driver.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   // init block
   input  logic              init_end,
   input  logic [3:0]        init_cmd,
   input  logic [1:0]        init_ba,
   input  logic [ADDR_W-1:0] init_addr,
   // auto-refresh block
   input  logic              aref_req,
   input  logic              aref_end,
   input  logic [3:0]        aref_cmd,
   input  logic [1:0]        aref_ba,
   input  logic [ADDR_W-1:0] aref_addr,
   output logic              aref_en,
   // write block
   input  logic              wr_req,
   input  logic              wr_end,
   input  logic [3:0]        wr_cmd,
   input  logic [1:0]        wr_ba,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_sdram_en,
   input  logic [DATA_W-1:0] wr_sdram_data,
   output logic              wr_en,
   // read block
   input  logic              rd_req,
   input  logic              rd_end,
   input  logic [3:0]        rd_cmd,
   input  logic [1:0]        rd_ba,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   output logic [DATA_W-1:0] rd_sdram_data,
   // chip pins
   sdram_arbit_if.master     pins,
   inout  wire  [DATA_W-1:0] sdram_dq
);

   localparam logic [31:0]       IDLE_ADDR_W32 = idle_addr_word();
   localparam logic [ADDR_W-1:0] IDLE_ADDR     = IDLE_ADDR_W32[ADDR_W-1:0];

   arb_state_e        state_q;
   logic [3:0]        cmd_s;
   logic [1:0]        ba_s;
   logic [ADDR_W-1:0] addr_s;
   logic              dq_oe_s;

   // Arbiter state machine: one owner at a time, always via ARBIT
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_INIT;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (init_end) state_q <= ST_ARBIT;
               else          state_q <= ST_INIT;
            end
            ST_ARBIT: begin
               if      (aref_req) state_q <= ST_AREF;
               else if (wr_req)   state_q <= ST_WRITE;
               else if (rd_req)   state_q <= ST_READ;
               else               state_q <= ST_ARBIT;
            end
            ST_AREF: begin
               if (aref_end) state_q <= ST_ARBIT;
               else          state_q <= ST_AREF;
            end
            ST_WRITE: begin
               if (wr_end) state_q <= ST_ARBIT;
               else        state_q <= ST_WRITE;
            end
            ST_READ: begin
               if (rd_end) state_q <= ST_ARBIT;
               else        state_q <= ST_READ;
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   // Grants decode straight from the state register, so reset clears them at once
   assign aref_en = (state_q == ST_AREF);
   assign wr_en   = (state_q == ST_WRITE);
   assign rd_en   = (state_q == ST_READ);

   // Command mux: the current owner's bus, or a parked NOP when nobody owns it
   always_comb begin
      cmd_s  = CMD_NOP;
      ba_s   = IDLE_BA;
      addr_s = IDLE_ADDR;
      case (state_q)
         ST_INIT: begin
            cmd_s  = init_cmd;
            ba_s   = init_ba;
            addr_s = init_addr;
         end
         ST_AREF: begin
            cmd_s  = aref_cmd;
            ba_s   = aref_ba;
            addr_s = aref_addr;
         end
         ST_WRITE: begin
            cmd_s  = wr_cmd;
            ba_s   = wr_ba;
            addr_s = wr_addr;
         end
         ST_READ: begin
            cmd_s  = rd_cmd;
            ba_s   = rd_ba;
            addr_s = rd_addr;
         end
         default: begin
            cmd_s  = CMD_NOP;
            ba_s   = IDLE_BA;
            addr_s = IDLE_ADDR;
         end
      endcase
   end

   assign pins.sdram_cke   = 1'b1;
   assign pins.sdram_cs_n  = cmd_s[3];
   assign pins.sdram_ras_n = cmd_s[2];
   assign pins.sdram_cas_n = cmd_s[1];
   assign pins.sdram_we_n  = cmd_s[0];
   assign pins.sdram_ba    = ba_s;
   assign pins.sdram_addr  = addr_s;

   // The write block may only drive DQ while it actually owns the bus
   assign dq_oe_s       = (state_q == ST_WRITE) && wr_sdram_en;
   assign sdram_dq      = dq_oe_s ? wr_sdram_data : {DATA_W{1'bz}};
   assign rd_sdram_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: a cycle table of stimulus plus expected owner,
// expected pin values pushed to a scoreboard queue and checked mid-cycle,
// followed by a hand-written asynchronous-reset sequence.
module tb_sdram_arbit;
   import sdram_pkg::*;

   localparam int DW = 16;
   localparam int AW = 11;

   // expected owner codes
   localparam int S_I = 0, S_A = 1, S_R = 2, S_W = 3, S_D = 4;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;

   logic          init_end = 1'b0;
   logic [3:0]    init_cmd = 4'b0000;
   logic [1:0]    init_ba = 2'b01;
   logic [AW-1:0] init_addr = 11'h123;
   logic          aref_req = 1'b0, aref_end = 1'b0;
   logic [3:0]    aref_cmd = 4'b0111;
   logic [1:0]    aref_ba = 2'b10;
   logic [AW-1:0] aref_addr = 11'h400;
   logic          wr_req = 1'b0, wr_end = 1'b0, wr_sdram_en = 1'b0;
   logic [3:0]    wr_cmd = 4'b0100;
   logic [1:0]    wr_ba = 2'b00;
   logic [AW-1:0] wr_addr = 11'h055;
   logic [DW-1:0] wr_sdram_data = 16'hA5A5;
   logic          rd_req = 1'b0, rd_end = 1'b0;
   logic [3:0]    rd_cmd = 4'b0101;
   logic [1:0]    rd_ba = 2'b01;
   logic [AW-1:0] rd_addr = 11'h2AA;
   logic          aref_en, wr_en, rd_en;
   logic [DW-1:0] rd_sdram_data;
   wire  [DW-1:0] sdram_dq;
   logic          tb_drv = 1'b0;
   logic [DW-1:0] tb_dq = 16'h3C3C;

   assign sdram_dq = tb_drv ? tb_dq : {DW{1'bz}};

   sdram_arbit_if #(.ADDR_W(AW)) pins ();

   sdram_arbit #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
      .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
      .aref_addr(aref_addr), .aref_en(aref_en),
      .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
      .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data), .wr_en(wr_en),
      .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
      .rd_en(rd_en), .rd_sdram_data(rd_sdram_data),
      .pins(pins), .sdram_dq(sdram_dq)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic       ie, arq, wrq, rdq, aend, wend, rend;
      logic [3:0] acmd;
      logic       wen, drv;
      int         sel;
      logic       chk_dq;
      logic [15:0] dq;
   } vec_t;

   typedef struct {
      int          step;
      logic [2:0]  gnt;
      logic [3:0]  cmd;
      logic [1:0]  ba;
      logic [10:0] addr;
      logic        chk_dq;
      logic [15:0] dq;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, req);
      end
   endtask

   task automatic add(input logic ie, arq, wrq, rdq, aend, wend, rend, input logic [3:0] acmd,
                      input logic wen, drv, input int sel, input logic cdq, input logic [15:0] dq);
      vec_t v;
      v.ie = ie; v.arq = arq; v.wrq = wrq; v.rdq = rdq;
      v.aend = aend; v.wend = wend; v.rend = rend; v.acmd = acmd;
      v.wen = wen; v.drv = drv; v.sel = sel; v.chk_dq = cdq; v.dq = dq;
      tbl.push_back(v);
   endtask

   // expected pins/grants for a given owner and the stimulus of that cycle
   function automatic exp_t model(input vec_t v, input int step);
      exp_t e;
      e.step = step; e.chk_dq = v.chk_dq; e.dq = v.dq;
      case (v.sel)
         S_I:     begin e.gnt = 3'b000; e.cmd = init_cmd; e.ba = init_ba; e.addr = init_addr; end
         S_R:     begin e.gnt = 3'b100; e.cmd = v.acmd;   e.ba = aref_ba; e.addr = aref_addr; end
         S_W:     begin e.gnt = 3'b010; e.cmd = wr_cmd;   e.ba = wr_ba;   e.addr = wr_addr;   end
         S_D:     begin e.gnt = 3'b001; e.cmd = rd_cmd;   e.ba = rd_ba;   e.addr = rd_addr;   end
         default: begin e.gnt = 3'b000; e.cmd = 4'b0111;  e.ba = 2'b11;   e.addr = 11'h7FF;   end
      endcase
      return e;
   endfunction

   task automatic check_pins(input string tag, input exp_t e);
      chk({tag, "_gnt"}, e.step, {29'd0, aref_en, wr_en, rd_en}, {29'd0, e.gnt});
      chk({tag, "_cmd"}, e.step,
          {28'd0, pins.sdram_cs_n, pins.sdram_ras_n, pins.sdram_cas_n, pins.sdram_we_n},
          {28'd0, e.cmd});
      chk({tag, "_ba"}, e.step, {30'd0, pins.sdram_ba}, {30'd0, e.ba});
      chk({tag, "_addr"}, e.step, {21'd0, pins.sdram_addr}, {21'd0, e.addr});
      chk({tag, "_cke"}, e.step, {31'd0, pins.sdram_cke}, 32'd1);
      if (e.chk_dq) begin
         chk({tag, "_dq"}, e.step, {16'd0, sdram_dq}, {16'd0, e.dq});
         chk({tag, "_rdata"}, e.step, {16'd0, rd_sdram_data}, {16'd0, e.dq});
      end
   endtask

   initial begin
      exp_t e;
      vec_t v;
      int   waited;

      //   ie   arq  wrq  rdq  aend wend rend acmd     wen  drv  owner chkdq dq
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0111,1'b0,1'b0,S_I,1'b0,16'h0000); // 0 wait init
      add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0111,1'b0,1'b0,S_I,1'b0,16'h0000); // 1 init_end
      add(1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4'b0111,1'b0,1'b0,S_A,1'b0,16'h0000); // 2 all request
      add(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,4'b0010,1'b0,1'b0,S_R,1'b0,16'h0000); // 3 precharge
      add(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,4'b0001,1'b0,1'b0,S_R,1'b0,16'h0000); // 4 auto-ref
      add(1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,4'b0111,1'b0,1'b0,S_R,1'b0,16'h0000); // 5 aref_end
      add(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,4'b0111,1'b0,1'b0,S_A,1'b0,16'h0000); // 6 gap
      add(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'b0111,1'b1,1'b0,S_W,1'b1,16'hA5A5); // 7 write data
      add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'b0111,1'b0,1'b0,S_W,1'b0,16'h0000); // 8 aref mid-write
      add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,4'b0111,1'b0,1'b0,S_W,1'b0,16'h0000); // 9 wr_end
      add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'b0111,1'b0,1'b0,S_A,1'b0,16'h0000); // 10 gap
      add(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'b0010,1'b0,1'b0,S_R,1'b0,16'h0000); // 11 refresh
      add(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,4'b0001,1'b0,1'b0,S_R,1'b0,16'h0000); // 12 aref_end
      add(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'b0111,1'b0,1'b0,S_A,1'b0,16'h0000); // 13 gap
      add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0111,1'b1,1'b1,S_D,1'b1,16'h3C3C); // 14 read, wen ignored
      add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'b0111,1'b1,1'b1,S_D,1'b1,16'h3C3C); // 15 rd_end
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0111,1'b1,1'b1,S_A,1'b1,16'h3C3C); // 16 init_end drop
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0111,1'b0,1'b0,S_A,1'b0,16'h0000); // 17 idle

      // reset state: init bus on the pins, no grants
      @(negedge sys_clk);
      v.sel = S_I; v.chk_dq = 1'b0; v.dq = 16'h0000; v.acmd = 4'b0111;
      check_pins("reset", model(v, -1));
      #2 sys_rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge sys_clk);
         #1;
         v = tbl[i];
         init_end = v.ie; aref_req = v.arq; wr_req = v.wrq; rd_req = v.rdq;
         aref_end = v.aend; wr_end = v.wend; rd_end = v.rend; aref_cmd = v.acmd;
         wr_sdram_en = v.wen; tb_drv = v.drv;
         sb.push_back(model(v, i));
         @(negedge sys_clk);
         e = sb.pop_front();
         check_pins("tbl", e);
      end

      // asynchronous reset in the middle of a write
      @(posedge sys_clk);
      #1;
      wr_req = 1'b1; aref_end = 1'b0; rd_end = 1'b0; wr_end = 1'b0;
      wr_sdram_en = 1'b0; tb_drv = 1'b0; init_end = 1'b1;
      waited = 0;
      while (!wr_en && waited < 8) begin
         @(negedge sys_clk);
         waited++;
      end
      chk("wr_grant_timeout", 100, {31'd0, wr_en}, 32'd1);
      @(posedge sys_clk);
      #3;
      wr_req = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      v.sel = S_I; v.chk_dq = 1'b0;
      check_pins("async_rst", model(v, 101));
      init_end = 1'b0;
      @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge sys_clk);
         check_pins("hold_init", model(v, 102 + k));
      end
      @(posedge sys_clk);
      #1 init_end = 1'b1;
      @(negedge sys_clk);
      check_pins("init_still", model(v, 105));
      @(negedge sys_clk);
      v.sel = S_A;
      check_pins("rearbit", model(v, 106));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard stop in case the sequence above stalls
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
